// File: rtl/serial_frame_rx.sv
// Serial frame receiver: samples a registered 1-bit stream on enabled clocks,
// deserializes LSB-first WIDTH-bit frames, checks the stop bit, counts good frames.
module serial_frame_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frm_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int            BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        STOP    = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     bitcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frm_err   <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // pulses drop on every edge that does not set them, en or not
            valid   <= 1'b0;
            frm_err <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: begin
                        if (!din) begin
                            state  <= DATA;
                            bitcnt <= '0;
                            busy   <= 1'b1;
                        end
                    end
                    DATA: begin
                        // right shift with din entering at MSB: first bit lands at LSB
                        shreg <= WIDTH'({din, shreg} >> 1);
                        if (bitcnt == LAST) begin
                            state  <= STOP;
                            bitcnt <= '0;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                        end
                    end
                    STOP: begin
                        if (din) begin
                            data      <= shreg;
                            valid     <= 1'b1;
                            frame_cnt <= frame_cnt + CNT_W'(1);
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            frm_err <= 1'b1;
                            state   <= WAIT_HI;
                        end
                    end
                    WAIT_HI: begin
                        // a held-low break must end before a new start is considered
                        if (din) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
